// File: rtl/ooop_types.sv
// Shared out-of-order core types: physical-register tags, FU classes and the
// reservation-station entry format, plus per-FU station depths used by dispatch.
package ooop_types;

  localparam int PREG_W = 6;
  localparam int ROB_W  = 5;
  localparam int XLEN   = 32;

  localparam int RS_ALU_DEPTH = 8;
  localparam int RS_BRU_DEPTH = 4;
  localparam int RS_LSU_DEPTH = 8;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_BRU = 2'd1,
    FU_LSU = 2'd2
  } fu_type_e;

  typedef struct packed {
    logic [PREG_W-1:0] prs1;
    logic              prs1_ready;
    logic [PREG_W-1:0] prs2;
    logic              prs2_ready;
    logic [PREG_W-1:0] prd;
    logic [ROB_W-1:0]  rob_tag;
    fu_type_e          fu;
    logic [XLEN-1:0]   imm;
  } rs_entry_t;

  // p0 is hard-wired ready, so a broadcast of tag 0 never counts as a wakeup
  function automatic logic cdb_hit(input logic              valid,
                                   input logic [PREG_W-1:0] bcast,
                                   input logic [PREG_W-1:0] tag);
    return valid && (bcast != '0) && (bcast == tag);
  endfunction

endpackage

// File: rtl/rs_select.sv
// Oldest-ready picker: grants the lowest-index requesting slot and reports
// its index alongside the one-hot grant.
module rs_select #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan high to low so the lowest requesting index is the last one written
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: holds dispatched entries until both
// operands are woken by the CDB and issues the oldest ready one.
module reservation_station
  import ooop_types::*;
#(
  parameter int DEPTH = RS_ALU_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              insert_valid_i,
  input  rs_entry_t         insert_entry_i,
  output logic              ready_o,
  input  logic              cdb_valid_i,
  input  logic [PREG_W-1:0] cdb_prd_i,
  output logic              issue_valid_o,
  input  logic              issue_ready_i,
  output rs_entry_t         issue_entry_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t        entry_q [DEPTH];
  rs_entry_t        entry_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  rs_entry_t        woke [DEPTH+1];
  logic [DEPTH:0]   woke_valid;
  rs_entry_t        insert_woke;

  logic [DEPTH-1:0] req;
  logic [DEPTH-1:0] grant;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             issue_fire;
  logic             insert_fire;
  logic [CNT_W-1:0] ins_pos;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      req[i] = valid_q[i] & entry_q[i].prs1_ready & entry_q[i].prs2_ready;
    end
  end

  rs_select #(
    .N     (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .req_i   (req),
    .grant_o (grant),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  assign ready_o       = (count_q < CNT_W'(DEPTH));
  assign issue_valid_o = sel_any;
  assign issue_fire    = sel_any & issue_ready_i;
  assign insert_fire   = insert_valid_i & ready_o;
  assign count_o       = count_q;

  always_comb begin
    issue_entry_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) issue_entry_o = entry_q[i];
    end
  end

  // Slot DEPTH is a permanently empty sentinel so the collapse can read i+1 everywhere
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i]            = entry_q[i];
      woke[i].prs1_ready = entry_q[i].prs1_ready |
                           cdb_hit(cdb_valid_i, cdb_prd_i, entry_q[i].prs1);
      woke[i].prs2_ready = entry_q[i].prs2_ready |
                           cdb_hit(cdb_valid_i, cdb_prd_i, entry_q[i].prs2);
      woke_valid[i]      = valid_q[i];
    end
    woke[DEPTH]       = '0;
    woke_valid[DEPTH] = 1'b0;

    insert_woke            = insert_entry_i;
    insert_woke.prs1_ready = insert_entry_i.prs1_ready |
                             cdb_hit(cdb_valid_i, cdb_prd_i, insert_entry_i.prs1);
    insert_woke.prs2_ready = insert_entry_i.prs2_ready |
                             cdb_hit(cdb_valid_i, cdb_prd_i, insert_entry_i.prs2);
  end

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    ins_pos = issue_fire ? (count_q - CNT_W'(1)) : count_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (i >= int'(sel_idx))) begin
        entry_d[i] = woke[i+1];
        valid_d[i] = woke_valid[i+1];
      end else begin
        entry_d[i] = woke[i];
        valid_d[i] = woke_valid[i];
      end
      if (insert_fire && (CNT_W'(i) == ins_pos)) begin
        entry_d[i] = insert_woke;
        valid_d[i] = 1'b1;
      end
    end

    count_d = count_q + CNT_W'(insert_fire) - CNT_W'(issue_fire);

    if (flush_i) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // Dispatch must honour ready_o; a dropped insert loses an instruction
  insert_when_full_a : assert property (
    @(posedge clk) disable iff (rst) !(insert_valid_i && !ready_o)
  ) else $warning("reservation_station: insert dropped while station full");

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: an expected-issue scoreboard drained
// by an independent monitor, plus direct checks of count/ready/valid.
module tb_reservation_station;
   import ooop_types::*;

   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              clk;
   logic              rst;
   logic              flush_i;
   logic              insert_valid_i;
   rs_entry_t         insert_entry_i;
   logic              ready_o;
   logic              cdb_valid_i;
   logic [PREG_W-1:0] cdb_prd_i;
   logic              issue_valid_o;
   logic              issue_ready_i;
   rs_entry_t         issue_entry_o;
   logic [CNT_W-1:0]  count_o;

   int        errorCount = 0;
   int        checkCount = 0;
   rs_entry_t expectedQueue[$];

   reservation_station #(
      .DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush_i        (flush_i),
      .insert_valid_i (insert_valid_i),
      .insert_entry_i (insert_entry_i),
      .ready_o        (ready_o),
      .cdb_valid_i    (cdb_valid_i),
      .cdb_prd_i      (cdb_prd_i),
      .issue_valid_o  (issue_valid_o),
      .issue_ready_i  (issue_ready_i),
      .issue_entry_o  (issue_entry_o),
      .count_o        (count_o)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Builds an entry whose payload fields are derived from the ROB tag
   function automatic rs_entry_t makeEntry(input int rob, input int p1, input logic r1,
                                           input int p2, input logic r2);
      rs_entry_t e;
      e            = '0;
      e.rob_tag    = ROB_W'(rob);
      e.prs1       = PREG_W'(p1);
      e.prs1_ready = r1;
      e.prs2       = PREG_W'(p2);
      e.prs2_ready = r2;
      e.prd        = PREG_W'(rob + 32);
      e.fu         = FU_ALU;
      e.imm        = 32'(rob * 16);
      return e;
   endfunction

   // What the FU must see for an entry: the same payload with both operands ready
   function automatic rs_entry_t expectIssued(input rs_entry_t e);
      rs_entry_t x;
      x            = e;
      x.prs1_ready = 1'b1;
      x.prs2_ready = 1'b1;
      return x;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Drives one cycle of inputs, waits past the next rising edge, then drops the one-shot strobes
   task automatic applyStimulus(input logic ins, input rs_entry_t e, input logic cdbV,
                                input int cdbP, input logic issRdy, input logic flush);
      insert_valid_i = ins;
      insert_entry_i = e;
      cdb_valid_i    = cdbV;
      cdb_prd_i      = PREG_W'(cdbP);
      issue_ready_i  = issRdy;
      flush_i        = flush;
      @(posedge clk);
      #1;
      insert_valid_i = 1'b0;
      insert_entry_i = '0;
      cdb_valid_i    = 1'b0;
      cdb_prd_i      = '0;
      flush_i        = 1'b0;
   endtask

   task automatic idle(input logic issRdy);
      applyStimulus(1'b0, '0, 1'b0, 0, issRdy, 1'b0);
   endtask

   // Monitor: every handshake that will fire at the next edge must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && !flush_i && issue_valid_o && issue_ready_i) begin
         checkCount++;
         if (expectedQueue.size() == 0) begin
            errorCount++;
            $display("[TB] FAIL unexpected_issue: got rob_tag %0d expected no issue",
                     issue_entry_o.rob_tag);
         end else begin
            rs_entry_t exp;
            exp = expectedQueue.pop_front();
            if (issue_entry_o !== exp) begin
               errorCount++;
               $display("[TB] FAIL issue_entry: got %0h (rob %0d) expected %0h (rob %0d)",
                        issue_entry_o, issue_entry_o.rob_tag, exp, exp.rob_tag);
            end
         end
      end
   end

   // Directed scenario sequence
   initial begin
      rs_entry_t a;
      rs_entry_t b;
      rs_entry_t c;
      rst            = 1'b1;
      flush_i        = 1'b0;
      insert_valid_i = 1'b0;
      insert_entry_i = '0;
      cdb_valid_i    = 1'b0;
      cdb_prd_i      = '0;
      issue_ready_i  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      checkOutput("reset_count", 64'(count_o), 64'd0);
      checkOutput("reset_ready", 64'(ready_o), 64'd1);
      checkOutput("reset_issue_valid", 64'(issue_valid_o), 64'd0);
      checkOutput("reset_issue_entry", 64'(issue_entry_o), 64'd0);

      // Basic issue
      a = makeEntry(3, 1, 1'b1, 2, 1'b1);
      expectedQueue.push_back(expectIssued(a));
      applyStimulus(1'b1, a, 1'b0, 0, 1'b1, 1'b0);
      checkOutput("basic_presented", 64'(issue_valid_o), 64'd1);
      idle(1'b1);
      checkOutput("basic_count_after", 64'(count_o), 64'd0);

      // Wakeup: younger ready entry overtakes older waiting one
      a = makeEntry(4, 12, 1'b0, 0, 1'b1);
      b = makeEntry(5, 3, 1'b1, 4, 1'b1);
      applyStimulus(1'b1, a, 1'b0, 0, 1'b1, 1'b0);
      expectedQueue.push_back(expectIssued(b));
      applyStimulus(1'b1, b, 1'b0, 0, 1'b1, 1'b0);
      idle(1'b1);
      checkOutput("wakeup_count_waiting", 64'(count_o), 64'd1);
      checkOutput("wakeup_not_ready", 64'(issue_valid_o), 64'd0);
      expectedQueue.push_back(expectIssued(a));
      applyStimulus(1'b0, '0, 1'b1, 12, 1'b1, 1'b0);
      checkOutput("wakeup_latency", 64'(issue_valid_o), 64'd1);
      idle(1'b1);
      checkOutput("wakeup_count_after", 64'(count_o), 64'd0);

      // Insert bypass of a coincident broadcast
      a = makeEntry(6, 0, 1'b1, 7, 1'b0);
      expectedQueue.push_back(expectIssued(a));
      applyStimulus(1'b1, a, 1'b1, 7, 1'b1, 1'b0);
      checkOutput("bypass_presented", 64'(issue_valid_o), 64'd1);
      idle(1'b1);
      checkOutput("bypass_count_after", 64'(count_o), 64'd0);

      // Fill under backpressure
      for (int k = 0; k < DEPTH; k++) begin
         applyStimulus(1'b1, makeEntry(8 + k, 1, 1'b1, 2, 1'b1), 1'b0, 0, 1'b0, 1'b0);
      end
      checkOutput("full_count", 64'(count_o), 64'd8);
      checkOutput("full_ready", 64'(ready_o), 64'd0);
      checkOutput("full_head_tag", 64'(issue_entry_o.rob_tag), 64'd8);
      applyStimulus(1'b1, makeEntry(20, 1, 1'b1, 2, 1'b1), 1'b0, 0, 1'b0, 1'b0);
      checkOutput("full_insert_ignored", 64'(count_o), 64'd8);
      checkOutput("stall_head_stable", 64'(issue_entry_o.rob_tag), 64'd8);
      expectedQueue.push_back(expectIssued(makeEntry(8, 1, 1'b1, 2, 1'b1)));
      applyStimulus(1'b1, makeEntry(21, 1, 1'b1, 2, 1'b1), 1'b0, 0, 1'b1, 1'b0);
      checkOutput("full_issue_count", 64'(count_o), 64'd7);
      checkOutput("full_issue_ready", 64'(ready_o), 64'd1);
      for (int k = 1; k < DEPTH; k++) begin
         expectedQueue.push_back(expectIssued(makeEntry(8 + k, 1, 1'b1, 2, 1'b1)));
      end
      repeat (DEPTH - 1) idle(1'b1);
      checkOutput("drain_count", 64'(count_o), 64'd0);

      // Age order after a single broadcast wakes three entries
      a = makeEntry(1, 20, 1'b0, 0, 1'b1);
      b = makeEntry(2, 20, 1'b0, 0, 1'b1);
      c = makeEntry(3, 20, 1'b0, 0, 1'b1);
      applyStimulus(1'b1, a, 1'b0, 0, 1'b0, 1'b0);
      applyStimulus(1'b1, b, 1'b0, 0, 1'b0, 1'b0);
      applyStimulus(1'b1, c, 1'b0, 0, 1'b0, 1'b0);
      checkOutput("age_none_ready", 64'(issue_valid_o), 64'd0);
      expectedQueue.push_back(expectIssued(a));
      expectedQueue.push_back(expectIssued(b));
      expectedQueue.push_back(expectIssued(c));
      applyStimulus(1'b0, '0, 1'b1, 20, 1'b1, 1'b0);
      checkOutput("age_count", 64'(count_o), 64'd3);
      repeat (3) idle(1'b1);
      checkOutput("age_count_after", 64'(count_o), 64'd0);

      // Simultaneous insert and issue with a single resident entry
      a = makeEntry(22, 5, 1'b1, 6, 1'b1);
      b = makeEntry(23, 7, 1'b1, 8, 1'b1);
      applyStimulus(1'b1, a, 1'b0, 0, 1'b0, 1'b0);
      expectedQueue.push_back(expectIssued(a));
      expectedQueue.push_back(expectIssued(b));
      applyStimulus(1'b1, b, 1'b0, 0, 1'b1, 1'b0);
      checkOutput("swap_count", 64'(count_o), 64'd1);
      idle(1'b1);
      checkOutput("swap_count_after", 64'(count_o), 64'd0);

      // Flush with five entries held and a coincident insert
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, makeEntry(24 + k, 1, 1'b1, 2, 1'b1), 1'b0, 0, 1'b0, 1'b0);
      end
      checkOutput("preflush_count", 64'(count_o), 64'd5);
      applyStimulus(1'b1, makeEntry(29, 1, 1'b1, 2, 1'b1), 1'b0, 0, 1'b0, 1'b1);
      checkOutput("flush_count", 64'(count_o), 64'd0);
      checkOutput("flush_issue_valid", 64'(issue_valid_o), 64'd0);
      checkOutput("flush_ready", 64'(ready_o), 64'd1);

      // Asynchronous reset while an entry is being presented
      applyStimulus(1'b1, makeEntry(30, 1, 1'b1, 2, 1'b1), 1'b0, 0, 1'b0, 1'b0);
      checkOutput("prereset_valid", 64'(issue_valid_o), 64'd1);
      issue_ready_i = 1'b1;
      rst           = 1'b1;
      #1;
      checkOutput("async_reset_valid", 64'(issue_valid_o), 64'd0);
      checkOutput("async_reset_count", 64'(count_o), 64'd0);
      checkOutput("async_reset_ready", 64'(ready_o), 64'd1);
      checkOutput("async_reset_entry", 64'(issue_entry_o), 64'd0);
      @(posedge clk);
      #1;
      issue_ready_i = 1'b0;
      rst           = 1'b0;
      idle(1'b0);

      checkOutput("scoreboard_drained", 64'(expectedQueue.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
